// File: rtl/regfile_mp_pkg.sv
// Shared defaults and FSM encoding for the multi-port integer register file.
package regfile_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam logic [XLEN_DEF-1:0] ZeroWord = '0;

  // Zero-init sequencer states
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one flag per register, set on issue, cleared by writeback.
// Per read port lookup reports an outstanding producer unless the value is
// being written back in the same cycle (the bypass already supplies it).
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_run,
  input  logic [NWR-1:0]          i_we,
  input  logic [NWR-1:0][AW-1:0]  i_waddr,
  input  logic                    i_iss_en,
  input  logic [AW-1:0]           i_iss_addr,
  input  logic [NRD-1:0]          i_re,
  input  logic [NRD-1:0][AW-1:0]  i_raddr,
  output logic [NRD-1:0]          o_rbusy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_nxt;

  // Decode issue (set) and writeback (clear) one-hot vectors
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_run && i_iss_en && i_iss_addr != '0) w_set[i_iss_addr] = 1'b1;
    for (int i = 0; i < NWR; i++)
      if (i_run && i_we[i]) w_clr[i_waddr[i]] = 1'b1;
    // set beats clear: the issuing instruction is a newer producer
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy flags, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Per-port hazard lookup, masked by a same-cycle writeback to that register
  always_comb begin
    o_rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      logic w_hit;
      w_hit = 1'b0;
      for (int i = 0; i < NWR; i++)
        if (i_we[i] && i_waddr[i] == i_raddr[j]) w_hit = 1'b1;
      o_rbusy[j] = i_run && i_re[j] && (i_raddr[j] != '0) &&
                   r_busy[i_raddr[j]] && !w_hit;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write integer register file with write-through
// bypass, hardwired x0, busy-bit scoreboard and a post-reset zero-init pass.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                init_done
);
  logic [NWR-1:0][AW-1:0]   w_waddr;
  logic [NWR-1:0][XLEN-1:0] w_wdata;
  logic [NRD-1:0][AW-1:0]   w_raddr;
  logic [NRD-1:0]           w_sb_busy;
  logic                     w_run;

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic            r_init_done, w_done_nxt;
  logic [XLEN-1:0] r_mem [NREG];

  assign w_waddr = waddr;
  assign w_wdata = wdata;
  assign w_raddr = raddr;
  // Gate with rst directly so outputs drop in the same instant reset asserts
  assign w_run   = rst && (r_state == ST_RUN);

  // Init sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_idx       <= AW'(1);
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_init_done <= w_done_nxt;
    end
  end

  // Init sequencer next state: walk x1..x(NREG-1), then run forever
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = r_init_done;
    case (r_state)
      ST_INIT: begin
        w_idx_nxt = r_idx + AW'(1);
        if (r_idx == AW'(NREG-1)) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign init_done = r_init_done;

  // Storage: zero-fill during init, otherwise prioritised writes (last port wins)
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_idx] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (we[i] && w_waddr[i] != '0) r_mem[w_waddr[i]] <= w_wdata[i];
    end
  end

  // Read ports: x0 and disabled ports read zero; same-cycle writes bypass the array
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [XLEN-1:0] w_rd;
    always_comb begin
      w_rd = XLEN'(ZeroWord);
      if (w_run && re[j] && w_raddr[j] != '0) begin
        w_rd = r_mem[w_raddr[j]];
        for (int i = 0; i < NWR; i++)
          if (we[i] && w_waddr[i] == w_raddr[j]) w_rd = w_wdata[i];
      end
    end
    assign rdata[j*XLEN +: XLEN] = w_rd;
  end

  regfile_scoreboard #(
    .NREG(NREG), .NRD(NRD), .NWR(NWR)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst),
    .i_run     (w_run),
    .i_we      (we),
    .i_waddr   (w_waddr),
    .i_iss_en  (iss_en),
    .i_iss_addr(iss_addr),
    .i_re      (re),
    .i_raddr   (w_raddr),
    .o_rbusy   (w_sb_busy)
  );

  assign rbusy = w_sb_busy;
endmodule
